fp16_add_ctrl: RTL and testbench
================================

# fp16_add_ctrl

Two-port round-robin scheduler and sequencer for the shared half-precision adder. It accepts operand pairs from two requesters and screens each pair through an internal exception classifier. Special-operand cases are answered directly. All other pairs go to the external multi-cycle fp16 adder core over a start/done handshake, with a timeout guard. Results return on a single response channel tagged with the requester id.

## Interface
- ADD_TIMEOUT, 64: maximum cycles spent waiting for `add_done` before a forced NaN response (≥2).

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester has an operand pair
- req0_ready / req1_ready  out  1  pair accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  16  IEEE-754 binary16 operands
- add_start  out  1  one-cycle start pulse to adder core
- add_a, add_b  out  16  operands to adder core
- add_done  in  1  adder result valid (single-cycle pulse)
- add_q  in  16  adder result
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_q  out  16  result
- rsp_id  out  1  originating requester
- rsp_exc  out  1  result came from the exception path or a timeout
- rsp_timeout  out  1  result forced by timeout

## Operation
- Reset: state IDLE, round-robin pointer = 0 (requester 0 preferred), wait counter 0, every output 0.
- FSM states:
  - IDLE
    - `reqN_ready` = (IDLE) & grant N; this is the only combinational valid→ready path.
    - Grant: the preferred requester if valid, else the other one.
    - On handshake, capture operands and id, then set pointer = other id. → CHECK.
  - CHECK: classify captured operands, first match wins.
    - Both NaN (exp=1F, mant≠0): sign A, exp 1F, smaller mantissa of the two.
    - A NaN: A. B NaN: B.
    - Either ±inf: inf, sign of A if A exp=1F else sign of B. inf + (−inf) returns inf, not NaN.
    - A zero: B. B zero: A.
    - Match: load `rsp_q`, set exc=1 → RESP. No `add_start`.
    - No match: `add_start`=1 this cycle, counter=0 → ADD_WAIT.
  - ADD_WAIT
    - `add_done`=1: load `add_q`, exc=0 → RESP.
    - Else, if counter = ADD_TIMEOUT−1: load 16'h7E00, exc=1, timeout=1 → RESP.
    - Else counter++.
    - `add_done` and the timeout in the same cycle: done wins.
  - RESP: `rsp_valid`=1. `rsp_q`/`rsp_id`/`rsp_exc`/`rsp_timeout` held stable until `rsp_ready`; handshake → IDLE.
- `add_a`/`add_b` always reflect the operand registers. They are meaningful only from CHECK through ADD_WAIT.
- `add_done` outside ADD_WAIT is ignored, including stale pulses after reset.
- Requester valid must not depend on ready. A requester not granted keeps its pair pending; no reordering within a requester.

## Timing
- Cycle 0: request handshake in IDLE. Cycle 1: CHECK.
- Exception path: `rsp_valid` from cycle 2; 3 cycles/op minimum with `rsp_ready` tied high.
- Adder path:
  - `add_start` in cycle 1; ADD_WAIT from cycle 2.
  - `add_done` in cycle k → `rsp_valid` in cycle k+1.
  - At most ADD_TIMEOUT cycles in ADD_WAIT.
- No new request accepted until the cycle after the response handshake.
- Reset mid-operation: the next cycle is IDLE with all outputs 0. The in-flight request is dropped without response; the pointer resets to 0.

## Structure
- Package `fp16_pkg`:
  - field widths (SIGN 1, EXP 5, MANT 10) and EXP_MAX = 5'h1F
  - QNAN = 16'h7E00
  - state enum {IDLE, CHECK, ADD_WAIT, RESP}
- Sub-module `fp16_exc_check`: purely combinational classifier. Inputs are the two 16-bit operands; outputs are `exc` and `q`, per the CHECK rules. The FSM, arbiter, counter and response registers sit in the top level.

## Test plan
- Normal add:
  - Stimulus: req0 a=16'h3C00, b=16'h4000; adder model returns 16'h4200 five cycles after start.
  - Expect: one `add_start` with those operands; `rsp_q`=4200, `rsp_exc`=0, `rsp_id`=0.
- Zero passthrough: req1 a=16'h0000, b=16'hC500 → no `add_start`; `rsp_q`=C500, `rsp_exc`=1, `rsp_id`=1, `rsp_valid` two cycles after handshake.
- NaN and infinity rules:
  - a=7E05, b=7C03 → 7C03.
  - a=7C00, b=FC00 → 7C00.
  - a=3C00, b=FE01 → FE01.
- Fairness: both requesters hold valid for 4 ops each → `rsp_id` sequence 0,1,0,1,…; after one req1-only op, the next tie grants req0.
- Timeout: ADD_TIMEOUT=8, `add_done` never asserted → `rsp_q`=7E00, `rsp_exc`=1, `rsp_timeout`=1 after exactly 8 ADD_WAIT cycles. A late `add_done` is ignored.
- Backpressure and reset:
  - `rsp_ready` low for 10 cycles → response stable, both readies low.
  - `rst` during ADD_WAIT → all outputs 0 next cycle; the following `add_done` produces no response.

Source files
------------

// File: rtl/fp16_pkg.sv
// fp16_pkg: shared definitions for the fp16 adder sequencer.
//   - binary16 field widths and special encodings
//   - FSM state encoding
//   - response record and operand-class helpers
package fp16_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 5;
  localparam int MANT_W = 10;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;
  localparam logic [15:0]      QNAN    = 16'h7E00;

  typedef enum logic [1:0] {IDLE, CHECK, ADD_WAIT, RESP} state_t;

  typedef struct packed {
    logic [15:0] q;
    logic        id;
    logic        exc;
    logic        timeout;
  } rsp_t;

  function automatic logic fp_is_nan(input logic [15:0] x);
    return (x[MANT_W +: EXP_W] == EXP_MAX) && (x[MANT_W-1:0] != '0);
  endfunction

  function automatic logic fp_is_inf(input logic [15:0] x);
    return (x[MANT_W +: EXP_W] == EXP_MAX) && (x[MANT_W-1:0] == '0);
  endfunction

  // +0 and -0 only; subnormals go to the adder.
  function automatic logic fp_is_zero(input logic [15:0] x);
    return x[MANT_W+EXP_W-1:0] == '0;
  endfunction

endpackage

// File: rtl/fp16_exc_check.sv
// fp16_exc_check: combinational special-operand classifier.
//   a, b : binary16 operands
//   exc  : pair is answered without the adder
//   q    : the direct answer (valid when exc=1)
// Rules are prioritised; the first matching one decides the answer.
module fp16_exc_check
  import fp16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        exc,
  output logic [15:0] q
);

  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [MANT_W-1:0]  a_m, b_m;
  logic               a_s, b_s;

  assign a_nan  = fp_is_nan(a);
  assign b_nan  = fp_is_nan(b);
  assign a_inf  = fp_is_inf(a);
  assign b_inf  = fp_is_inf(b);
  assign a_zero = fp_is_zero(a);
  assign b_zero = fp_is_zero(b);
  assign a_m    = a[MANT_W-1:0];
  assign b_m    = b[MANT_W-1:0];
  assign a_s    = a[MANT_W+EXP_W];
  assign b_s    = b[MANT_W+EXP_W];

  always_comb begin
    exc = 1'b1;
    q   = '0;
    if (a_nan && b_nan)
      q = {a_s, EXP_MAX, (a_m < b_m) ? a_m : b_m};
    else if (a_nan)
      q = a;
    else if (b_nan)
      q = b;
    else if (a_inf || b_inf)
      // opposite infinities deliberately give inf (sign of A), not NaN
      q = {a_inf ? a_s : b_s, EXP_MAX, {MANT_W{1'b0}}};
    else if (a_zero)
      q = b;
    else if (b_zero)
      q = a;
    else
      exc = 1'b0;
  end

endmodule

// File: rtl/fp16_add_ctrl.sv
// fp16_add_ctrl: two-port round-robin front end for a shared multi-cycle
// fp16 adder.
//   clk, rst                : clock, synchronous active-high reset
//   reqN_valid/ready/a/b    : requester N operand pair (ready is the only
//                             combinational path, valid -> ready in IDLE)
//   add_start/a/b, done/q   : start/done handshake to the adder core
//   rsp_valid/ready         : response handshake
//   rsp_q/id/exc/timeout    : result, requester id, exception/timeout flags
// Special operands are answered locally; a stuck adder is cut off after
// ADD_TIMEOUT cycles with a quiet NaN.
module fp16_add_ctrl
  import fp16_pkg::*;
#(
  parameter int ADD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        add_start,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic        add_done,
  input  logic [15:0] add_q,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_q,
  output logic        rsp_id,
  output logic        rsp_exc,
  output logic        rsp_timeout
);

  localparam int                CNT_W    = (ADD_TIMEOUT > 2) ? $clog2(ADD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ADD_TIMEOUT - 1);

  state_t            state;
  logic              ptr;      // preferred requester on a tie
  logic [CNT_W-1:0]  cnt;
  logic              id_r;
  logic              exc_r;
  logic [15:0]       exc_q_r;
  rsp_t              rsp_r;

  logic              gnt_any, gnt_id;
  logic [15:0]       in_a, in_b;
  logic              chk_exc;
  logic [15:0]       chk_q;

  // Grant: preferred requester if valid, else whichever is valid.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = ptr ? req1_valid : (req1_valid & ~req0_valid);
  end

  // Gated by rst so no handshake is signalled in a cycle the FSM discards.
  assign req0_ready = ~rst & (state == IDLE) & gnt_any & ~gnt_id;
  assign req1_ready = ~rst & (state == IDLE) & gnt_any &  gnt_id;

  assign in_a = gnt_id ? req1_a : req0_a;
  assign in_b = gnt_id ? req1_b : req0_b;

  // The classifier looks at the granted pair while it is captured so the
  // verdict is already registered in CHECK; this lets add_start be a flop
  // that is high exactly during CHECK.
  fp16_exc_check u_exc (
    .a   (in_a),
    .b   (in_b),
    .exc (chk_exc),
    .q   (chk_q)
  );

  assign rsp_q       = rsp_r.q;
  assign rsp_id      = rsp_r.id;
  assign rsp_exc     = rsp_r.exc;
  assign rsp_timeout = rsp_r.timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cnt       <= '0;
      id_r      <= 1'b0;
      exc_r     <= 1'b0;
      exc_q_r   <= '0;
      add_start <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            add_a     <= in_a;
            add_b     <= in_b;
            id_r      <= gnt_id;
            ptr       <= ~gnt_id;
            exc_r     <= chk_exc;
            exc_q_r   <= chk_q;
            add_start <= ~chk_exc;
            state     <= CHECK;
          end
        end
        CHECK: begin
          add_start <= 1'b0;
          cnt       <= '0;
          if (exc_r) begin
            rsp_r     <= '{q: exc_q_r, id: id_r, exc: 1'b1, timeout: 1'b0};
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            state     <= ADD_WAIT;
          end
        end
        ADD_WAIT: begin
          // done has priority over a coincident timeout
          if (add_done) begin
            rsp_r     <= '{q: add_q, id: id_r, exc: 1'b0, timeout: 1'b0};
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_r     <= '{q: QNAN, id: id_r, exc: 1'b1, timeout: 1'b1};
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_add_ctrl.sv
// Self-checking bench for fp16_add_ctrl: directed steps plus randomized
// streams scored against a behavioural model of the classifier, the
// round-robin rule and a stand-in adder.
module tb_fp16_add_ctrl;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        add_start, add_done;
  logic [15:0] add_a, add_b, add_q;
  logic        rsp_valid, rsp_id, rsp_exc, rsp_timeout;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_q;

  int          checks = 0, errors = 0;
  int          start_cnt = 0;
  int          add_lat = 3;       // <0: random 1..5 per operation
  logic [15:0] seen_a = '0, seen_b = '0;
  logic        pref = 1'b0;       // model of the tie-break preference
  int          mdl_lat;
  logic [15:0] mdl_r;

  always #5 clk = ~clk;

  fp16_add_ctrl #(.ADD_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_done(add_done), .add_q(add_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q),
    .rsp_id(rsp_id), .rsp_exc(rsp_exc), .rsp_timeout(rsp_timeout)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Stand-in adder: a recognisable function of the operands, not real fp math.
  function automatic logic [15:0] fake_add(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h3C00 && b == 16'h4000) return 16'h4200;
    return a ^ b ^ 16'h1234;
  endfunction

  // Reference answer for a pair, from the special-value rules.
  function automatic void ref_op(input logic [15:0] a, input logic [15:0] b,
                                 output logic e, output logic [15:0] q);
    logic an, bn, ai, bi, az, bz;
    logic [15:0] ma, mb;
    an = (a & 16'h7FFF) > 16'h7C00;
    bn = (b & 16'h7FFF) > 16'h7C00;
    ai = (a & 16'h7FFF) == 16'h7C00;
    bi = (b & 16'h7FFF) == 16'h7C00;
    az = (a & 16'h7FFF) == 16'h0000;
    bz = (b & 16'h7FFF) == 16'h0000;
    ma = a & 16'h03FF;
    mb = b & 16'h03FF;
    e = 1'b1;
    if (an && bn)      q = (a & 16'h8000) | 16'h7C00 | ((ma < mb) ? ma : mb);
    else if (an)       q = a;
    else if (bn)       q = b;
    else if (ai || bi) q = ((ai ? a : b) & 16'h8000) | 16'h7C00;
    else if (az)       q = b;
    else if (bz)       q = a;
    else begin
      e = 1'b0;
      q = fake_add(a, b);
    end
  endfunction

  function automatic logic [15:0] rand_opnd();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       return {s, 15'h0000};
      1:       return {s, 15'h7C00};
      2:       return {s, 5'h1F, 10'($urandom_range(1, 1023))};
      default: return {s, 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
    endcase
  endfunction

  // Adder core model: add_done one pulse, add_lat cycles after the start cycle.
  initial begin
    add_done = 1'b0;
    add_q    = '0;
    forever begin
      @(posedge clk); #1;
      if (add_start === 1'b1) begin
        start_cnt++;
        seen_a  = add_a;
        seen_b  = add_b;
        mdl_lat = (add_lat < 0) ? int'($urandom_range(1, 5)) : add_lat;
        mdl_r   = fake_add(add_a, add_b);
        repeat (mdl_lat) @(posedge clk);
        #1;
        add_done = 1'b1;
        add_q    = mdl_r;
        @(posedge clk); #1;
        add_done = 1'b0;
        add_q    = '0;
      end
    end
  end

  // One operation on one requester, entered and left at posedge+1.
  // exp_cyc counts cycles from the handshake cycle (0) to first rsp_valid.
  task automatic single(input string tag, input logic id, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_q,
                        input logic exp_exc, input logic exp_to, input int exp_cyc);
    int c, s0, exp_starts;
    s0 = start_cnt;
    exp_starts = (exp_to || !exp_exc) ? 1 : 0;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    c = 0;
    while ((id ? req1_ready : req0_ready) !== 1'b1 && c < 20) begin
      @(posedge clk); #2; c++;
    end
    chk1({tag, " grant"}, id ? req1_ready : req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    pref = ~id;
    c = 1;
    while (rsp_valid !== 1'b1 && c < 100) begin
      @(posedge clk); #1; c++;
    end
    chki ({tag, " latency"}, c, exp_cyc);
    chk16({tag, " q"}, rsp_q, exp_q);
    chk1 ({tag, " id"}, rsp_id, id);
    chk1 ({tag, " exc"}, rsp_exc, exp_exc);
    chk1 ({tag, " timeout"}, rsp_timeout, exp_to);
    chki ({tag, " starts"}, start_cnt - s0, exp_starts);
    if (exp_starts == 1) begin
      chk16({tag, " add_a"}, seen_a, a);
      chk16({tag, " add_b"}, seen_b, b);
    end
    @(posedge clk); #1;
    chk1({tag, " rsp consumed"}, rsp_valid, 1'b0);
  endtask

  // Both requesters stream random pairs; grants follow the round-robin rule
  // and responses are scored in grant order.
  task automatic run_stream(input string tag, input int n0, input int n1);
    logic [15:0] a0[$], b0[$], a1[$], b1[$], eq_q[$];
    logic        eid_q[$], eexc_q[$];
    logic        exp_id, e;
    logic [15:0] q;
    int          guard, got;
    for (int i = 0; i < n0; i++) begin a0.push_back(rand_opnd()); b0.push_back(rand_opnd()); end
    for (int i = 0; i < n1; i++) begin a1.push_back(rand_opnd()); b1.push_back(rand_opnd()); end
    add_lat = -1;
    guard = 0;
    got = 0;
    while (got < n0 + n1 && guard < 2000) begin
      req0_valid = a0.size() > 0;
      req1_valid = a1.size() > 0;
      if (a0.size() > 0) begin req0_a = a0[0]; req0_b = b0[0]; end
      if (a1.size() > 0) begin req1_a = a1[0]; req1_b = b1[0]; end
      #1;
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        exp_id = (a0.size() > 0 && a1.size() > 0) ? pref : (a1.size() > 0);
        chk1({tag, " grant id"}, req1_ready, exp_id);
        chk1({tag, " single grant"}, req0_ready & req1_ready, 1'b0);
        if (req1_ready === 1'b1) begin
          ref_op(a1[0], b1[0], e, q);
          void'(a1.pop_front()); void'(b1.pop_front());
        end else begin
          ref_op(a0[0], b0[0], e, q);
          void'(a0.pop_front()); void'(b0.pop_front());
        end
        eq_q.push_back(q); eexc_q.push_back(e); eid_q.push_back(req1_ready);
        pref = ~req1_ready;
      end
      if (rsp_valid === 1'b1) begin
        got++;
        if (eq_q.size() == 0) begin
          chki({tag, " unexpected rsp"}, 1, 0);
        end else begin
          chk16({tag, " q"}, rsp_q, eq_q.pop_front());
          chk1 ({tag, " id"}, rsp_id, eid_q.pop_front());
          chk1 ({tag, " exc"}, rsp_exc, eexc_q.pop_front());
          chk1 ({tag, " timeout"}, rsp_timeout, 1'b0);
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chki({tag, " responses"}, got, n0 + n1);
  endtask

  initial begin
    logic ok;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk1 ("reset rsp_valid", rsp_valid, 1'b0);
    chk1 ("reset add_start", add_start, 1'b0);
    chk16("reset rsp_q", rsp_q, 16'h0000);
    chk16("reset add_a", add_a, 16'h0000);
    chk1 ("reset ready0", req0_ready, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // normal add through the adder core
    add_lat = 5;
    single("add", 1'b0, 16'h3C00, 16'h4000, 16'h4200, 1'b0, 1'b0, 7);

    // zero passthrough and NaN / infinity rules
    single("zero", 1'b1, 16'h0000, 16'hC500, 16'hC500, 1'b1, 1'b0, 2);
    single("nan2", 1'b0, 16'h7E05, 16'h7C03, 16'h7C03, 1'b1, 1'b0, 2);
    single("infs", 1'b1, 16'h7C00, 16'hFC00, 16'h7C00, 1'b1, 1'b0, 2);
    single("nanb", 1'b0, 16'h3C00, 16'hFE01, 16'hFE01, 1'b1, 1'b0, 2);
    single("bzer", 1'b0, 16'h4400, 16'h8000, 16'h4400, 1'b1, 1'b0, 2);

    // fairness: alternating ties, then a req1-only op, then a tie to req0
    run_stream("fair", 4, 4);
    single("r1only", 1'b1, 16'h0000, 16'h3C00, 16'h3C00, 1'b1, 1'b0, 2);
    run_stream("tie", 1, 1);

    // timeout with a late add_done that must be ignored
    add_lat = 12;
    single("tmo", 1'b0, 16'h3C00, 16'h3800, 16'h7E00, 1'b1, 1'b1, 2 + T);
    ok = 1'b1;
    repeat (6) begin
      if (rsp_valid !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk1("late done ignored", ok, 1'b1);

    // backpressure: response held, both readies low
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h0000; req0_b = 16'h3C00;
    #1;
    chk1("bp grant", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_a = 16'h3C00; req0_b = 16'h3C00;
    req1_valid = 1'b1; req1_a = 16'h4000; req1_b = 16'h4000;
    pref = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk1 ("bp valid", rsp_valid, 1'b1);
      chk16("bp q", rsp_q, 16'h3C00);
      chk1 ("bp id", rsp_id, 1'b0);
      chk1 ("bp readies", req0_ready | req1_ready, 1'b0);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk1("bp released", rsp_valid, 1'b0);

    // reset during ADD_WAIT; pointer was 1 before it
    add_lat = 6;
    req0_valid = 1'b1; req0_a = 16'h3C00; req0_b = 16'h3800;
    #1;
    chk1("rst grant", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk1 ("rst rsp_valid", rsp_valid, 1'b0);
    chk16("rst rsp_q", rsp_q, 16'h0000);
    chk1 ("rst rsp_exc", rsp_exc | rsp_timeout | rsp_id, 1'b0);
    chk1 ("rst add_start", add_start, 1'b0);
    chk16("rst add_a", add_a | add_b, 16'h0000);
    rst = 1'b0;
    pref = 1'b0;
    ok = 1'b1;
    repeat (8) begin
      if (rsp_valid !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk1("stale done ignored", ok, 1'b1);
    run_stream("post rst tie", 1, 1);

    // randomized traffic
    run_stream("rand", 12, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
